// File: rtl/store_align.sv
// Store-path alignment: places store bytes on memory lanes with byte enables.
// Define STORE_ALIGN_SPLIT_EN to split misaligned stores into two beats; otherwise they are flagged.
module store_align (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_data,
   input  logic [1:0]  in_size,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic        err
);

   localparam int unsigned DW = 32;
   localparam int unsigned BW = 4;

`ifdef STORE_ALIGN_SPLIT_EN
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FIRST = 2'd2} state_t;
`else
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1} state_t;
`endif

   state_t          state, state_n;
   logic [DW-1:0]   addr_n, wdata_n;
   logic [BW-1:0]   be_n;
   logic            err_n;

   logic [1:0]      off;
   logic [BW-1:0]   mask, be1;
   logic [DW-1:0]   base, data1;
   logic            bad, accept, drain;

`ifdef STORE_ALIGN_SPLIT_EN
   logic [DW-1:0]   b2_addr, b2_wdata, b2_addr_n, b2_wdata_n;
   logic [BW-1:0]   b2_be, b2_be_n;
   logic [DW-1:0]   data2;
   logic [BW-1:0]   be2;
   logic [2:0]      nbytes;
   logic            split;
`endif

   // Expand byte enables into a bit mask so disabled lanes carry zero.
   function automatic logic [DW-1:0] lane_mask(input logic [BW-1:0] be);
      logic [DW-1:0] m;
      m = '0;
      for (int k = 0; k < BW; k++) m[8*k +: 8] = {8{be[k]}};
      return m;
   endfunction

   // Beat construction from the incoming request.
   always_comb begin
      off   = in_addr[1:0];
      base  = {in_addr[31:2], 2'b00};
      case (in_size)
         2'b00:   mask = 4'b0001;
         2'b01:   mask = 4'b0011;
         2'b10:   mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      be1   = 4'({4'b0000, mask} << off);
      data1 = (in_data << {off, 3'b000}) & lane_mask(be1);
`ifdef STORE_ALIGN_SPLIT_EN
      case (in_size)
         2'b00:   nbytes = 3'd1;
         2'b01:   nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
      split = (3'(off) + nbytes) > 3'd4;
      be2   = mask >> (3'd4 - 3'(off));
      data2 = (in_data >> (6'd32 - 6'({off, 3'b000}))) & lane_mask(be2);
      bad   = (in_size == 2'b11);
`else
      bad   = (in_size == 2'b11) || (in_size == 2'b01 && in_addr[0]) ||
              (in_size == 2'b10 && off != 2'b00);
`endif
   end

   always_comb begin
      mem_valid = (state != EMPTY);
      in_ready  = reset && (state == EMPTY || (state == ONE && mem_ready));
      accept    = in_valid && in_ready;
      drain     = mem_valid && mem_ready;
   end

   // Next-state and output-register logic.
   always_comb begin
      state_n = state;
      addr_n  = mem_addr;
      wdata_n = mem_wdata;
      be_n    = mem_be;
      err_n   = 1'b0;
`ifdef STORE_ALIGN_SPLIT_EN
      b2_addr_n  = b2_addr;
      b2_wdata_n = b2_wdata;
      b2_be_n    = b2_be;
`endif
      case (state)
         EMPTY, ONE: begin
            if (accept) begin
               if (bad) begin
                  err_n = 1'b1;
                  if (drain) state_n = EMPTY;
               end else begin
                  addr_n  = base;
                  wdata_n = data1;
                  be_n    = be1;
                  state_n = ONE;
`ifdef STORE_ALIGN_SPLIT_EN
                  if (split) begin
                     state_n    = FIRST;
                     b2_addr_n  = base + 32'd4;
                     b2_wdata_n = data2;
                     b2_be_n    = be2;
                  end
`endif
               end
            end else if (drain) begin
               state_n = EMPTY;
            end
         end
`ifdef STORE_ALIGN_SPLIT_EN
         FIRST: begin
            if (mem_ready) begin
               addr_n  = b2_addr;
               wdata_n = b2_wdata;
               be_n    = b2_be;
               state_n = ONE;
            end
         end
`endif
         default: state_n = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= EMPTY;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         err       <= 1'b0;
`ifdef STORE_ALIGN_SPLIT_EN
         b2_addr   <= '0;
         b2_wdata  <= '0;
         b2_be     <= '0;
`endif
      end else begin
         state     <= state_n;
         mem_addr  <= addr_n;
         mem_wdata <= wdata_n;
         mem_be    <= be_n;
         err       <= err_n;
`ifdef STORE_ALIGN_SPLIT_EN
         b2_addr   <= b2_addr_n;
         b2_wdata  <= b2_wdata_n;
         b2_be     <= b2_be_n;
`endif
      end
   end

endmodule
